// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out frame receiver.
//   - FSM state encoding (IDLE..HOLD)
//   - parity_bit(): expected parity of a data word (even, or odd when requested)
package sipo_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] DATA = 3'd1;
   localparam logic [2:0] PAR  = 3'd2;
   localparam logic [2:0] STOP = 3'd3;
   localparam logic [2:0] HOLD = 3'd4;

   // Data narrower than 32 bits is zero-extended, which does not change the XOR.
   function automatic logic parity_bit(input logic [31:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit left-shift register with shift enable.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low clear
//   shift_en : shift one position left this cycle
//   sin      : bit entering at the LSB
//   q        : register contents (first bit shifted in ends up at the MSB)
module sipo_shift_en #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (shift_en) sr_d = {sr_q[WIDTH-2:0], sin};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
   end

   assign q = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start(0), WIDTH data bits MSB first, optional parity,
// stop(1). The assembled word is held until the consumer takes it.
//   clk, rst_n  : clock / asynchronous active-low reset
//   sdi         : serial bit, qualified by sdi_valid (one cycle per bit)
//   dout        : received word, valid while dout_valid=1
//   dout_ready  : consumer accepts the held word
//   parity_err  : parity mismatch on the held word
//   frame_err   : stop bit was 0 on the held word
//   overrun     : sticky, a start bit arrived while a word was still held
//   busy        : receiver not idle
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sdi,
   input  logic             sdi_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             shift_en;
   logic [WIDTH-1:0] shift_q;

   sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .sin      (sdi),
      .q        (shift_q)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      ovr_d    = ovr_q;
      shift_en = 1'b0;
      case (state_q)
         IDLE: if (sdi_valid && !sdi) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: if (sdi_valid) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PAR : STOP;
         end
         PAR: if (sdi_valid) begin
            perr_d  = sdi ^ parity_bit(32'(shift_q), PARITY_ODD != 0);
            state_d = STOP;
         end
         STOP: if (sdi_valid) begin
            ferr_d  = ~sdi;
            state_d = HOLD;
         end
         HOLD: begin
            // Transfer wins: serial input is ignored in the accept cycle, so a
            // start bit there neither drops a frame nor keeps overrun set.
            if (dout_ready) begin
               state_d = IDLE;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               ovr_d   = 1'b0;
            end else if (sdi_valid && !sdi) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout       = shift_q;
   assign dout_valid = (state_q == HOLD);
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: an 8-bit even-parity receiver and a 4-bit no-parity receiver.
module tb_sipo_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sdi = 1'b1, sdi_valid = 1'b0, dout_ready = 1'b1;
   logic [7:0] dout;
   logic       dout_valid, parity_err, frame_err, overrun, busy;

   logic       sdi4 = 1'b1, sdi_valid4 = 1'b0, dout_ready4 = 1'b1;
   logic [3:0] dout4;
   logic       dout_valid4, parity_err4, frame_err4, overrun4, busy4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
      .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .sdi(sdi4), .sdi_valid(sdi_valid4),
      .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4),
      .parity_err(parity_err4), .frame_err(frame_err4), .overrun(overrun4), .busy(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; the bit is taken on the following posedge and the
   // task returns at the negedge after it.
   task automatic send_bit(input bit u4, input logic b, input int gap);
      if (u4) begin sdi4 = b; sdi_valid4 = 1'b1; end
      else    begin sdi  = b; sdi_valid  = 1'b1; end
      @(negedge clk);
      sdi_valid  = 1'b0;
      sdi_valid4 = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
      send_bit(0, 1'b0, gap);
      for (int i = 7; i >= 0; i--) send_bit(0, d[i], gap);
      send_bit(0, p, gap);
      send_bit(0, s, 0);
   endtask

   task automatic chk_held(input string tag, input logic [7:0] d, input logic pe, input logic fe);
      chk({tag, "_dv"},   32'(dout_valid), 32'd1);
      chk({tag, "_dout"}, 32'(dout),       32'(d));
      chk({tag, "_perr"}, 32'(parity_err), 32'(pe));
      chk({tag, "_ferr"}, 32'(frame_err),  32'(fe));
   endtask

   // With dout_ready=1 the held word goes on the next edge.
   task automatic chk_released(input string tag);
      @(negedge clk);
      chk({tag, "_dv_off"},   32'(dout_valid), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy),       32'd0);
      chk({tag, "_perr_off"}, 32'(parity_err), 32'd0);
      chk({tag, "_ferr_off"}, 32'(frame_err),  32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_dv",   32'(dout_valid), 32'd0);
      chk("rst_busy", 32'(busy),       32'd0);
      chk("rst_ovr",  32'(overrun),    32'd0);
      chk("rst_dout", 32'(dout),       32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle-line 1s are not start bits.
      send_bit(0, 1'b1, 0);
      chk("idle_one_busy", 32'(busy), 32'd0);

      // Clean frame A5 (four ones -> even parity bit 0).
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      chk_held("a5", 8'hA5, 1'b0, 1'b0);
      chk_released("a5");

      // Wrong parity bit.
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      chk_held("par", 8'hA5, 1'b1, 1'b0);
      chk_released("par");

      // Stop bit 0.
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      chk_held("stop", 8'hA5, 1'b0, 1'b1);
      chk_released("stop");

      // Held word with consumer stalled, then a start bit arrives.
      dout_ready = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      chk_held("hold", 8'hA5, 1'b0, 1'b0);
      chk("hold_ovr_pre", 32'(overrun), 32'd0);
      send_bit(0, 1'b0, 0);
      send_bit(0, 1'b1, 2);
      chk("ovr_set",  32'(overrun),    32'd1);
      chk("ovr_dout", 32'(dout),       32'hA5);
      chk("ovr_dv",   32'(dout_valid), 32'd1);
      chk("ovr_busy", 32'(busy),       32'd1);
      dout_ready = 1'b1;
      @(negedge clk);
      chk("ovr_clr",     32'(overrun),    32'd0);
      chk("ovr_dv_off",  32'(dout_valid), 32'd0);
      chk("ovr_busy_off",32'(busy),       32'd0);

      // Gaps of 3 idle cycles between bits.
      send_frame(8'hA5, 1'b0, 1'b1, 3);
      chk_held("gap", 8'hA5, 1'b0, 1'b0);
      chk_released("gap");

      // Reset after four data bits.
      send_bit(0, 1'b0, 0);
      for (int i = 7; i >= 4; i--) send_bit(0, 1'b1, 0);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy),       32'd0);
      chk("mid_rst_dv",   32'(dout_valid), 32'd0);
      chk("mid_rst_dout", 32'(dout),       32'd0);
      chk("mid_rst_ovr",  32'(overrun),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(8'h3C, 1'b0, 1'b1, 0);
      chk_held("3c", 8'h3C, 1'b0, 1'b0);
      chk_released("3c");

      // 4-bit, no parity: stop follows the last data bit directly.
      send_bit(1, 1'b0, 0);
      send_bit(1, 1'b1, 0);
      send_bit(1, 1'b1, 0);
      send_bit(1, 1'b0, 0);
      send_bit(1, 1'b1, 0);
      chk("w4_busy_pre", 32'(busy4),       32'd1);
      chk("w4_dv_pre",   32'(dout_valid4), 32'd0);
      send_bit(1, 1'b1, 0);
      chk("w4_dv",   32'(dout_valid4), 32'd1);
      chk("w4_dout", 32'(dout4),       32'hD);
      chk("w4_perr", 32'(parity_err4), 32'd0);
      chk("w4_ferr", 32'(frame_err4),  32'd0);
      @(negedge clk);
      chk("w4_dv_off", 32'(dout_valid4), 32'd0);
      chk("w4_ovr",    32'(overrun4),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 = a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sdi  input  1  serial data bit.
REQ-007 SHALL have port sdi_valid  input  1  qualifies sdi for exactly one clk cycle per serial bit.
REQ-008 SHALL have port dout  output  WIDTH  assembled word, first-received bit in the MSB.
REQ-009 SHALL have port dout_valid  output  1  a word is held on dout.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port parity_err  output  1  parity mismatch on the held word.
REQ-012 SHALL have port frame_err  output  1  stop bit was 0 on the held word.
REQ-013 SHALL have port overrun  output  1  sticky flag: a start bit was dropped while in HOLD.
REQ-014 SHALL have port busy  output  1  FSM is not in IDLE.

Function
REQ-015 SHALL define the frame as start(0), then WIDTH data bits MSB first, then parity (only if PARITY_EN), then stop(1); only cycles with sdi_valid=1 count as bits.
REQ-016 SHALL implement FSM states IDLE, DATA, PAR, STOP, HOLD.
REQ-017 IDLE: on sdi_valid=1 with sdi=0, SHALL go to DATA; sdi_valid=1 with sdi=1 is ignored.
REQ-018 DATA: on each sdi_valid, SHALL shift left with sdi entering at the LSB and increment the bit counter; after the WIDTH-th bit, SHALL go to PAR if PARITY_EN, else to STOP.
REQ-019 PAR: on sdi_valid, SHALL compare sdi with the expected parity (XOR of the data, inverted if PARITY_ODD) and register the mismatch; then SHALL go to STOP.
REQ-020 STOP: on sdi_valid, SHALL register frame_err = ~sdi, go to HOLD, and assert dout_valid in the next cycle.
REQ-021 HOLD: dout, parity_err and frame_err SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-022 HOLD: dout_valid=1 and dout_ready=1 in the same cycle SHALL complete the transfer, deassert dout_valid, clear both error flags, and return to IDLE next cycle.
REQ-023 HOLD without transfer: sdi_valid=1 with sdi=0 SHALL set overrun and drop the frame; in the transfer cycle, sdi_valid SHALL be ignored without setting overrun.
REQ-024 overrun SHALL clear only on a completed transfer (REQ-022), and only when no new drop occurs in that cycle.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide, reset to 0 on entering DATA, and never wrap inside a frame.
REQ-026 Cycles with sdi_valid=0 SHALL leave all state unchanged (arbitrary gaps between bits are legal).
REQ-027 dout SHALL be driven only from the shift register; dout SHALL be don't-care while dout_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, counter=0, shift register=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial or held word; the first frame after rst_n rises SHALL begin with a fresh start bit.

Structure
REQ-030 State encoding (localparams IDLE..HOLD) and the parity helper function SHALL live in the shared package sipo_pkg.
REQ-031 The shift datapath SHALL be one sub-module, sipo_shift_en (WIDTH-parameterised shift register with shift-enable and async active-low clear); the FSM, counter and flags SHALL stay in sipo_frame_ctrl.

Verification (WIDTH=8, PARITY_EN=1, PARITY_ODD=0 unless stated)
REQ-032 Bits 0,1010_0101,0,1, each with sdi_valid, dout_ready=1 -> dout=8'hA5, dout_valid for 1 cycle, no errors.
REQ-033 Same frame with parity bit=1 -> dout=8'hA5, parity_err=1; with stop bit=0 -> frame_err=1.
REQ-034 dout_ready=0 and a second start bit sent in HOLD -> overrun=1, dout stays 8'hA5; dout_ready=1 -> transfer, overrun cleared, busy=0.
REQ-035 Same frame with 3 idle cycles between each bit -> result identical to REQ-032.
REQ-036 rst_n pulsed low after 4 data bits -> all outputs 0 at once; the next full frame 8'h3C is received correctly.
REQ-037 PARITY_EN=0, WIDTH=4: frame 0,1101,1 -> dout=4'hD with no parity cycle.
